// File: rtl/vector_mac_array.sv
// -----------------------------------------------------------------------------
// vector_mac_array
//
// Computes NCH signed dot products in parallel over one DIM-element input
// vector. Each channel has its own weight column in each of 2^PW weight
// banks ("phases") and its own bias. The accumulated sum goes through an
// arithmetic right shift, a bias add, saturation to DW bits and an optional
// ReLU. The NCH results are then streamed out in channel order over a
// valid/ready port. No new input is accepted while results are being drained.
//
// Ports:
//   CLK, RST                 clock (rising edge), async active-high reset
//   DIN_VALID/DIN_READY/DIN  input element stream (signed DW bits)
//   PHASE_SEL, SHIFT, RELU_EN  per-vector controls, sampled on element 0
//   W_WEN/W_REN/W_ADDR/W_WDATA/W_RDATA
//                            weight memory port, address {phase, ch, elem},
//                            registered read data
//   B_WEN/B_ADDR/B_WDATA     bias memory write port
//   OUT/OUT_CH/OUT_VALID/OUT_READY/OUT_LAST
//                            result stream, one channel per handshake
//   BUSY                     high whenever a vector is in progress
// -----------------------------------------------------------------------------
module vector_mac_array #(
    parameter int DIM = 16,
    parameter int AW  = 4,
    parameter int NCH = 4,
    parameter int CW  = 2,
    parameter int PW  = 3,
    parameter int DW  = 16,
    parameter int SW  = 5
) (
    input  logic                 CLK,
    input  logic                 RST,

    input  logic                 DIN_VALID,
    output logic                 DIN_READY,
    input  logic [DW-1:0]        DIN,
    input  logic [PW-1:0]        PHASE_SEL,
    input  logic [SW-1:0]        SHIFT,
    input  logic                 RELU_EN,

    input  logic                 W_WEN,
    input  logic                 W_REN,
    input  logic [PW+CW+AW-1:0]  W_ADDR,
    input  logic [DW-1:0]        W_WDATA,
    output logic [DW-1:0]        W_RDATA,

    input  logic                 B_WEN,
    input  logic [CW-1:0]        B_ADDR,
    input  logic [DW-1:0]        B_WDATA,

    output logic [DW-1:0]        OUT,
    output logic [CW-1:0]        OUT_CH,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic                 OUT_LAST,
    output logic                 BUSY
);

    localparam int ACCW   = 2*DW + AW;
    localparam int WAW    = PW + CW + AW;
    localparam int WDEPTH = 1 << WAW;

    // Saturation bounds expressed at the width of the biased sum.
    localparam logic signed [ACCW:0] SAT_MAX = (ACCW+1)'((1 << (DW-1)) - 1);
    localparam logic signed [ACCW:0] SAT_MIN = -SAT_MAX - (ACCW+1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        EMIT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              drainCnt_q, drainCnt_d;
    logic [CW-1:0]     outCh_q, outCh_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic [SW-1:0]     shift_q, shift_d;
    logic              relu_q, relu_d;

    logic              dinHs;
    logic              firstHs;
    logic              latchResults;
    logic              lastElem;
    logic [AW-1:0]     elemIdx;
    logic [PW-1:0]     phaseEff;

    logic                   prodValid_q;
    logic signed [2*DW-1:0] prod_q   [NCH];
    logic signed [2*DW-1:0] prodFull [NCH];
    logic signed [ACCW-1:0] acc_q    [NCH];
    logic [DW-1:0]          res_q    [NCH];
    logic [DW-1:0]          resNext  [NCH];
    logic [DW-1:0]          wSel     [NCH];

    logic [DW-1:0]     wMem [WDEPTH];
    logic [DW-1:0]     bMem [NCH];
    logic [DW-1:0]     wRdata_q;

    // Shift, bias, saturate and ReLU one accumulated sum. The bias add is
    // one bit wider than the accumulator so it can never wrap before the
    // saturation compare.
    function automatic logic [DW-1:0] calcResult(
        input logic signed [ACCW-1:0] acc,
        input logic [SW-1:0]          sh,
        input logic [DW-1:0]          bias,
        input logic                   relu
    );
        logic signed [ACCW-1:0] shifted;
        logic signed [ACCW:0]   sum;
        logic [DW-1:0]          sat;
        shifted = acc >>> sh;
        sum = $signed({shifted[ACCW-1], shifted})
            + $signed({{(ACCW+1-DW){bias[DW-1]}}, bias});
        if (sum > SAT_MAX) begin
            sat = {1'b0, {(DW-1){1'b1}}};
        end else if (sum < SAT_MIN) begin
            sat = {1'b1, {(DW-1){1'b0}}};
        end else begin
            sat = sum[DW-1:0];
        end
        if (relu && sat[DW-1]) begin
            sat = '0;
        end
        return sat;
    endfunction

    assign DIN_READY = (state_q == IDLE) || (state_q == ACCUM);
    assign dinHs     = DIN_VALID && DIN_READY;
    assign BUSY      = (state_q != IDLE);

    // The first element of a vector arrives before the per-vector controls
    // are latched, so it must address the weights with the live PHASE_SEL
    // and element index 0.
    assign elemIdx  = (state_q == IDLE) ? '0 : cnt_q;
    assign phaseEff = (state_q == IDLE) ? PHASE_SEL : phase_q;
    assign lastElem = (elemIdx == AW'(DIM-1));

    assign OUT       = res_q[outCh_q];
    assign OUT_CH    = outCh_q;
    assign OUT_VALID = (state_q == EMIT);
    assign OUT_LAST  = (state_q == EMIT) && (outCh_q == CW'(NCH-1));
    assign W_RDATA   = wRdata_q;

    // Per-channel weight fetch, full-width signed product and result math.
    for (genvar g = 0; g < NCH; g++) begin : gChan
        assign wSel[g]     = wMem[{phaseEff, CW'(g), elemIdx}];
        assign prodFull[g] = $signed({{DW{DIN[DW-1]}}, DIN})
                           * $signed({{DW{wSel[g][DW-1]}}, wSel[g]});
        assign resNext[g]  = calcResult(acc_q[g], shift_q, bMem[g], relu_q);
    end

    // Control state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            drainCnt_q <= 1'b0;
            outCh_q    <= '0;
            phase_q    <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drainCnt_q <= drainCnt_d;
            outCh_q    <= outCh_d;
            phase_q    <= phase_d;
            shift_q    <= shift_d;
            relu_q     <= relu_d;
        end
    end

    // Next-state logic. DRAIN covers the two cycles needed for the last
    // product to be registered and then accumulated; results are captured
    // on the way out of DRAIN.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        drainCnt_d   = drainCnt_q;
        outCh_d      = outCh_q;
        phase_d      = phase_q;
        shift_d      = shift_q;
        relu_d       = relu_q;
        firstHs      = 1'b0;
        latchResults = 1'b0;
        case (state_q)
            IDLE, ACCUM: begin
                if (dinHs) begin
                    if (state_q == IDLE) begin
                        firstHs = 1'b1;
                        phase_d = PHASE_SEL;
                        shift_d = SHIFT;
                        relu_d  = RELU_EN;
                    end
                    if (lastElem) begin
                        state_d    = DRAIN;
                        cnt_d      = '0;
                        drainCnt_d = 1'b0;
                    end else begin
                        state_d = ACCUM;
                        cnt_d   = elemIdx + AW'(1);
                    end
                end
            end
            DRAIN: begin
                if (drainCnt_q) begin
                    state_d      = EMIT;
                    drainCnt_d   = 1'b0;
                    outCh_d      = '0;
                    latchResults = 1'b1;
                end else begin
                    drainCnt_d = 1'b1;
                end
            end
            EMIT: begin
                if (OUT_READY) begin
                    if (outCh_q == CW'(NCH-1)) begin
                        state_d = IDLE;
                        outCh_d = '0;
                    end else begin
                        outCh_d = outCh_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: products are registered on the input handshake and folded
    // into the accumulators one cycle later. The first handshake of a
    // vector clears the accumulators; its own product lands the cycle after.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prodValid_q <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                prod_q[c] <= '0;
                acc_q[c]  <= '0;
                res_q[c]  <= '0;
            end
        end else begin
            prodValid_q <= dinHs;
            for (int c = 0; c < NCH; c++) begin
                if (dinHs) begin
                    prod_q[c] <= prodFull[c];
                end
                if (firstHs) begin
                    acc_q[c] <= '0;
                end else if (prodValid_q) begin
                    acc_q[c] <= acc_q[c] + {{AW{prod_q[c][2*DW-1]}}, prod_q[c]};
                end
                if (latchResults) begin
                    res_q[c] <= resNext[c];
                end
            end
        end
    end

    // Weight and bias storage is deliberately not reset so that a reset
    // in the middle of a vector keeps the programmed coefficients. Writes
    // are locked out while a vector is in flight.
    always_ff @(posedge CLK) begin
        if (W_WEN && !BUSY) begin
            wMem[W_ADDR] <= W_WDATA;
        end
        if (B_WEN && !BUSY) begin
            bMem[B_ADDR] <= B_WDATA;
        end
    end

    // Registered weight readback, held between read strobes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wRdata_q <= '0;
        end else if (W_REN) begin
            wRdata_q <= wMem[W_ADDR];
        end
    end

endmodule

// File: tb/tb_vector_mac_array.sv
// -----------------------------------------------------------------------------
// tb_vector_mac_array
//
// Directed, table-driven bench for vector_mac_array. Fixed weight banks are
// loaded once; each table record selects a bank, input pattern, shift,
// ReLU, biases and the four hand-computed results. Hand-written sequences
// cover reset, readback, backpressure, write lockout and mid-vector reset.
// -----------------------------------------------------------------------------
module tb_vector_mac_array;

    localparam int DIM = 16;
    localparam int NCH = 4;
    localparam int DW  = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        DIN_VALID;
    logic        DIN_READY;
    logic [15:0] DIN;
    logic [2:0]  PHASE_SEL;
    logic [4:0]  SHIFT;
    logic        RELU_EN;
    logic        W_WEN;
    logic        W_REN;
    logic [8:0]  W_ADDR;
    logic [15:0] W_WDATA;
    logic [15:0] W_RDATA;
    logic        B_WEN;
    logic [1:0]  B_ADDR;
    logic [15:0] B_WDATA;
    logic [15:0] OUT;
    logic [1:0]  OUT_CH;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic        OUT_LAST;
    logic        BUSY;

    int nApplied = 0;
    int nMiss    = 0;

    typedef struct {
        logic             constMode;
        logic [15:0]      dinConst;
        logic [2:0]       phase;
        logic [4:0]       shift;
        logic             relu;
        logic             gaps;
        logic [3:0][15:0] bias;
        logic [3:0][15:0] exp;
    } vec_t;

    vec_t vecs [11];

    vector_mac_array dut (
        .CLK       (CLK),
        .RST       (RST),
        .DIN_VALID (DIN_VALID),
        .DIN_READY (DIN_READY),
        .DIN       (DIN),
        .PHASE_SEL (PHASE_SEL),
        .SHIFT     (SHIFT),
        .RELU_EN   (RELU_EN),
        .W_WEN     (W_WEN),
        .W_REN     (W_REN),
        .W_ADDR    (W_ADDR),
        .W_WDATA   (W_WDATA),
        .W_RDATA   (W_RDATA),
        .B_WEN     (B_WEN),
        .B_ADDR    (B_ADDR),
        .B_WDATA   (B_WDATA),
        .OUT       (OUT),
        .OUT_CH    (OUT_CH),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_LAST  (OUT_LAST),
        .BUSY      (BUSY)
    );

    // 100 MHz-style free-running clock.
    always #5 CLK = ~CLK;

    // Global time limit so the run can never hang.
    initial begin
        #800000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [3:0][15:0] q4(input logic [15:0] a0, input logic [15:0] a1,
                                            input logic [15:0] a2, input logic [15:0] a3);
        logic [3:0][15:0] r;
        r[0] = a0;
        r[1] = a1;
        r[2] = a2;
        r[3] = a3;
        return r;
    endfunction

    function automatic vec_t mkVec(input logic cm, input logic [15:0] dc, input logic [2:0] ph,
                                   input logic [4:0] sh, input logic rl, input logic gp,
                                   input logic [3:0][15:0] b, input logic [3:0][15:0] e);
        vec_t v;
        v.constMode = cm;
        v.dinConst  = dc;
        v.phase     = ph;
        v.shift     = sh;
        v.relu      = rl;
        v.gaps      = gp;
        v.bias      = b;
        v.exp       = e;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nApplied++;
        if (actual !== expected) begin
            nMiss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic writeWeight(input int ph, input int ch, input int e, input logic [15:0] data);
        W_WEN   = 1'b1;
        W_ADDR  = {3'(ph), 2'(ch), 4'(e)};
        W_WDATA = data;
        @(negedge CLK);
        W_WEN   = 1'b0;
    endtask

    task automatic writeBias(input int ch, input logic [15:0] data);
        B_WEN   = 1'b1;
        B_ADDR  = 2'(ch);
        B_WDATA = data;
        @(negedge CLK);
        B_WEN   = 1'b0;
    endtask

    task automatic readWeight(input int ph, input int ch, input int e);
        W_REN  = 1'b1;
        W_ADDR = {3'(ph), 2'(ch), 4'(e)};
        @(negedge CLK);
        W_REN  = 1'b0;
    endtask

    task automatic loadWeights();
        for (int c = 0; c < NCH; c++) begin
            for (int e = 0; e < DIM; e++) begin
                writeWeight(0, c, e, (c == 0) ? 16'd1 : (c == 1) ? 16'd2 : 16'd0);
                writeWeight(1, c, e, 16'h7FFF);
                case (c)
                    0:       writeWeight(2, c, e, 16'd1);
                    1:       writeWeight(2, c, e, (e == 0) ? 16'hFFF7 : 16'd0);
                    2:       writeWeight(2, c, e, 16'hFFFF);
                    default: writeWeight(2, c, e, (e == 15) ? 16'd1 : 16'd0);
                endcase
                writeWeight(3, c, e, 16'(c*16 + e - 20));
            end
        end
    endtask

    // Feeds up to stopAfter elements; per-vector controls are scrambled after
    // the first element to show they are sampled only once.
    task automatic feedVector(input vec_t v, input int stopAfter);
        int t;
        for (int e = 0; e < DIM; e++) begin
            if (v.gaps && e > 0 && ($urandom_range(0, 2) == 0)) begin
                DIN_VALID = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge CLK);
            end
            DIN_VALID = 1'b1;
            DIN       = v.constMode ? v.dinConst : 16'(e + 1);
            if (e == 0) begin
                PHASE_SEL = v.phase;
                SHIFT     = v.shift;
                RELU_EN   = v.relu;
            end
            t = 0;
            while (!DIN_READY && t < 50) begin
                @(negedge CLK);
                t++;
            end
            if (t == 50) checkOutput("din_ready_wait", DIN_READY, 1);
            @(negedge CLK);
            if (e == 0) begin
                PHASE_SEL = ~v.phase;
                SHIFT     = ~v.shift;
                RELU_EN   = ~v.relu;
            end
            if (e + 1 == stopAfter) begin
                DIN_VALID = 1'b0;
                return;
            end
        end
        DIN_VALID = 1'b0;
    endtask

    // Drains the four results. At holdCh the consumer stalls for 5 cycles
    // and tries weight/bias writes, which must be ignored while busy.
    task automatic collectResults(input int idx, input logic [3:0][15:0] exp, input int holdCh);
        int t;
        for (int c = 0; c < NCH; c++) begin
            t = 0;
            while (!OUT_VALID && t < 20) begin
                @(negedge CLK);
                t++;
            end
            checkOutput($sformatf("v%0d_valid_ch%0d", idx, c), OUT_VALID, 1);
            checkOutput($sformatf("v%0d_out_ch%0d", idx, c), OUT, exp[c]);
            checkOutput($sformatf("v%0d_outch_ch%0d", idx, c), OUT_CH, c);
            checkOutput($sformatf("v%0d_last_ch%0d", idx, c), OUT_LAST, (c == NCH-1) ? 1 : 0);
            if (c == holdCh) begin
                OUT_READY = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    if (k == 1) begin
                        W_WEN = 1'b1; W_ADDR = 9'h000; W_WDATA = 16'h1234;
                        B_WEN = 1'b1; B_ADDR = 2'd0;   B_WDATA = 16'h0100;
                    end else begin
                        W_WEN = 1'b0;
                        B_WEN = 1'b0;
                    end
                    @(negedge CLK);
                    checkOutput($sformatf("hold%0d_out", k), OUT, exp[c]);
                    checkOutput($sformatf("hold%0d_outch", k), OUT_CH, c);
                    checkOutput($sformatf("hold%0d_valid", k), OUT_VALID, 1);
                    checkOutput($sformatf("hold%0d_dinready", k), DIN_READY, 0);
                end
                W_WEN = 1'b0;
                B_WEN = 1'b0;
            end
            OUT_READY = 1'b1;
            @(negedge CLK);
        end
        OUT_READY = 1'b0;
        checkOutput($sformatf("v%0d_busy_after", idx), BUSY, 0);
    endtask

    // One full vector: optional bias load, feed, latency check, drain.
    task automatic applyStimulus(input int idx, input logic loadBias, input int holdCh);
        vec_t v;
        v = vecs[idx];
        if (loadBias) begin
            for (int c = 0; c < NCH; c++) writeBias(c, v.bias[c]);
        end
        feedVector(v, DIM);
        checkOutput($sformatf("v%0d_lat_e0", idx), OUT_VALID, 0);
        checkOutput($sformatf("v%0d_dinready_drain", idx), DIN_READY, 0);
        checkOutput($sformatf("v%0d_busy_drain", idx), BUSY, 1);
        @(negedge CLK);
        checkOutput($sformatf("v%0d_lat_e1", idx), OUT_VALID, 0);
        @(negedge CLK);
        checkOutput($sformatf("v%0d_lat_e2", idx), OUT_VALID, 1);
        collectResults(idx, v.exp, holdCh);
    endtask

    initial begin
        RST = 1'b1;
        DIN_VALID = 1'b0; DIN = '0; PHASE_SEL = '0; SHIFT = '0; RELU_EN = 1'b0;
        W_WEN = 1'b0; W_REN = 1'b0; W_ADDR = '0; W_WDATA = '0;
        B_WEN = 1'b0; B_ADDR = '0; B_WDATA = '0; OUT_READY = 1'b0;

        //           cm  const     ph    sh     rl  gp  biases                                   expected results
        vecs[0]  = mkVec(0, 16'h0000, 3'd0, 5'd0,  0, 0, q4(16'h0000,16'h0000,16'h0000,16'h0000), q4(16'h0088,16'h0110,16'h0000,16'h0000));
        vecs[1]  = mkVec(0, 16'h0000, 3'd0, 5'd0,  0, 1, q4(16'h0000,16'h0000,16'h0000,16'h0000), q4(16'h0088,16'h0110,16'h0000,16'h0000));
        vecs[2]  = mkVec(1, 16'h7FFF, 3'd1, 5'd0,  0, 0, q4(16'h0000,16'h0000,16'h0000,16'h0000), q4(16'h7FFF,16'h7FFF,16'h7FFF,16'h7FFF));
        vecs[3]  = mkVec(1, 16'h8000, 3'd1, 5'd0,  0, 0, q4(16'h0000,16'h0000,16'h0000,16'h0000), q4(16'h8000,16'h8000,16'h8000,16'h8000));
        vecs[4]  = mkVec(1, 16'h8000, 3'd1, 5'd0,  1, 0, q4(16'h0000,16'h0000,16'h0000,16'h0000), q4(16'h0000,16'h0000,16'h0000,16'h0000));
        vecs[5]  = mkVec(0, 16'h0000, 3'd2, 5'd3,  0, 0, q4(16'hFFEC,16'h0000,16'h0000,16'h0000), q4(16'hFFFD,16'hFFFE,16'hFFEF,16'h0002));
        vecs[6]  = mkVec(0, 16'h0000, 3'd2, 5'd1,  0, 0, q4(16'h0000,16'h0000,16'h0000,16'h0000), q4(16'h0044,16'hFFFB,16'hFFBC,16'h0008));
        vecs[7]  = mkVec(0, 16'h0000, 3'd2, 5'd1,  1, 0, q4(16'h0000,16'h0000,16'h0064,16'hFFF6), q4(16'h0044,16'h0000,16'h0020,16'h0000));
        vecs[8]  = mkVec(0, 16'h0000, 3'd3, 5'd0,  0, 0, q4(16'h0000,16'h0000,16'h0000,16'h0000), q4(16'hFAB0,16'h0330,16'h0BB0,16'h1430));
        vecs[9]  = mkVec(0, 16'h0000, 3'd3, 5'd31, 0, 0, q4(16'h0005,16'h0005,16'h0005,16'h0005), q4(16'h0004,16'h0005,16'h0005,16'h0005));
        vecs[10] = mkVec(0, 16'h0000, 3'd0, 5'd0,  0, 0, q4(16'h7FF0,16'h8000,16'hFFFF,16'h7FFF), q4(16'h7FFF,16'h8110,16'hFFFF,16'h7FFF));

        // Reset values while reset is held.
        repeat (3) @(negedge CLK);
        checkOutput("rst_dinready", DIN_READY, 1);
        checkOutput("rst_wrdata",   W_RDATA, 0);
        checkOutput("rst_out",      OUT, 0);
        checkOutput("rst_outch",    OUT_CH, 0);
        checkOutput("rst_outvalid", OUT_VALID, 0);
        checkOutput("rst_outlast",  OUT_LAST, 0);
        checkOutput("rst_busy",     BUSY, 0);
        RST = 1'b0;
        @(negedge CLK);

        loadWeights();

        // Registered readback, held when the strobe is low.
        readWeight(3, 2, 5);
        checkOutput("rd_p3c2e5", W_RDATA, 16'h0011);
        W_ADDR = {3'd0, 2'd1, 4'd3};
        @(negedge CLK);
        checkOutput("rd_hold", W_RDATA, 16'h0011);
        readWeight(0, 1, 3);
        checkOutput("rd_p0c1e3", W_RDATA, 16'h0002);

        $display("[TB] running table vectors");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(i, 1'b1, -1);
        end

        $display("[TB] backpressure and busy write lockout");
        applyStimulus(0, 1'b1, 1);
        readWeight(0, 0, 0);
        checkOutput("lockout_weight", W_RDATA, 16'h0001);

        $display("[TB] reset in the middle of a vector");
        feedVector(vecs[8], 7);
        checkOutput("midvec_busy", BUSY, 1);
        RST = 1'b1;
        #1;
        checkOutput("midrst_dinready", DIN_READY, 1);
        checkOutput("midrst_wrdata",   W_RDATA, 0);
        checkOutput("midrst_out",      OUT, 0);
        checkOutput("midrst_outch",    OUT_CH, 0);
        checkOutput("midrst_outvalid", OUT_VALID, 0);
        checkOutput("midrst_outlast",  OUT_LAST, 0);
        checkOutput("midrst_busy",     BUSY, 0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        // Biases are not reloaded: the blocked bias write must not show up.
        applyStimulus(0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
        $finish;
    end

endmodule
